wb_accel_bridge: RTL

WB_ACCEL_BRIDGE -- requirements
Module: wb_accel_bridge

---
 rtl/wb_accel_bridge.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/wb_accel_bridge.sv
// Wishbone bridge from an upstream network-adapter master to a single accelerator slave.
// Decodes an address window, forwards one transaction at a time and bounds the wait with a timeout.
module wb_accel_bridge #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_F000,
    parameter int unsigned TIMEOUT   = 256
) (
    input  logic        clk,
    input  logic        rst_sys_n,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_we_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic        busy_o,
    output logic [7:0]  err_cnt_o
);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    localparam logic [15:0] WaitLast = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [31:0] wbm_adr_q, wbm_adr_d;
    logic [31:0] wbm_dat_q, wbm_dat_d;
    logic [3:0]  wbm_sel_q, wbm_sel_d;
    logic        wbm_we_q, wbm_we_d;
    logic        req_q, req_d;
    logic [31:0] wbs_dat_q, wbs_dat_d;
    logic        wbs_ack_q, wbs_ack_d;
    logic        wbs_err_q, wbs_err_d;
    logic        busy_q, busy_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [15:0] wait_q, wait_d;

    logic        in_window;
    logic        count_err;

    assign in_window = (wbs_adr_i & ADDR_MASK) == ADDR_BASE;

    always_comb begin
        state_d   = state_q;
        wbm_adr_d = wbm_adr_q;
        wbm_dat_d = wbm_dat_q;
        wbm_sel_d = wbm_sel_q;
        wbm_we_d  = wbm_we_q;
        req_d     = req_q;
        wbs_dat_d = wbs_dat_q;
        wbs_ack_d = 1'b0;
        wbs_err_d = 1'b0;
        wait_d    = wait_q;
        count_err = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    if (in_window) begin
                        wbm_adr_d = wbs_adr_i & ~ADDR_MASK;
                        wbm_dat_d = wbs_dat_i;
                        wbm_sel_d = wbs_sel_i;
                        wbm_we_d  = wbs_we_i;
                        req_d     = 1'b1;
                        wait_d    = 16'd0;
                        state_d   = StReq;
                    end else begin
                        wbs_err_d = 1'b1;
                        count_err = 1'b1;
                        state_d   = StResp;
                    end
                end
            end
            StReq: begin
                wait_d = wait_q + 16'd1;
                // An upstream abort takes precedence: the master no longer wants any reply.
                if (!wbs_cyc_i) begin
                    req_d   = 1'b0;
                    state_d = StIdle;
                end else if (wbm_ack_i || wbm_err_i) begin
                    wbs_dat_d = wbm_dat_i;
                    req_d     = 1'b0;
                    wbs_err_d = wbm_err_i;
                    wbs_ack_d = ~wbm_err_i;
                    count_err = wbm_err_i;
                    state_d   = StResp;
                end else if (wait_q == WaitLast) begin
                    req_d     = 1'b0;
                    wbs_err_d = 1'b1;
                    count_err = 1'b1;
                    state_d   = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                req_d   = 1'b0;
                state_d = StIdle;
            end
        endcase

        err_cnt_d = err_cnt_q;
        if (count_err && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
        busy_d = state_d != StIdle;
    end

    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state_q   <= StIdle;
            wbm_adr_q <= '0;
            wbm_dat_q <= '0;
            wbm_sel_q <= '0;
            wbm_we_q  <= 1'b0;
            req_q     <= 1'b0;
            wbs_dat_q <= '0;
            wbs_ack_q <= 1'b0;
            wbs_err_q <= 1'b0;
            busy_q    <= 1'b0;
            err_cnt_q <= '0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            wbm_adr_q <= wbm_adr_d;
            wbm_dat_q <= wbm_dat_d;
            wbm_sel_q <= wbm_sel_d;
            wbm_we_q  <= wbm_we_d;
            req_q     <= req_d;
            wbs_dat_q <= wbs_dat_d;
            wbs_ack_q <= wbs_ack_d;
            wbs_err_q <= wbs_err_d;
            busy_q    <= busy_d;
            err_cnt_q <= err_cnt_d;
            wait_q    <= wait_d;
        end
    end

    assign wbs_dat_o = wbs_dat_q;
    assign wbs_ack_o = wbs_ack_q;
    assign wbs_err_o = wbs_err_q;
    assign wbm_adr_o = wbm_adr_q;
    assign wbm_dat_o = wbm_dat_q;
    assign wbm_sel_o = wbm_sel_q;
    assign wbm_we_o  = wbm_we_q;
    assign wbm_cyc_o = req_q;
    assign wbm_stb_o = req_q;
    assign busy_o    = busy_q;
    assign err_cnt_o = err_cnt_q;

endmodule
